lfsr_arb: RTL
=============

LFSR_ARB -- requirements
Module: lfsr_arb

Interface
REQ-001 SHALL have parameter GP_NUM_REQ, default 4: number of requesters, range 2..8.
REQ-002 SHALL have parameter GP_SHK_WAIT, default 8: cycles to wait after a reshuffle trigger before serving draws, range 1..255.
REQ-003 SHALL have parameter GP_RESHUFFLE_PERIOD, default 256: draws between automatic reshuffles, range 1..65535; used only when LFSR_ARB_AUTO_SHK_EN is defined.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all logic rising-edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port req, input, GP_NUM_REQ bits: level draw request, one bit per requester.
REQ-007 SHALL have port shk_req, input, 1 bit: single-cycle pulse requesting a reshuffle.
REQ-008 SHALL have port gnt, output, GP_NUM_REQ bits: one-hot, one-cycle grant, coincident with rnd_vld.
REQ-009 SHALL have port rnd_vld, output, 1 bit: rnd_data is valid this cycle.
REQ-010 SHALL have port rnd_data, output, 16 bits: random value delivered to the granted requester.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-012 SHALL have port gen_en, output, 1 bit: LFSR step enable.
REQ-013 SHALL have port rgen_trg, output, 1 bit: LFSR reshuffle trigger.
REQ-014 SHALL have port lfsr, input, 16 bits: current LFSR value.

Function
REQ-015 SHALL implement FSM states IDLE, STEP, DELIVER, SHK_TRG, SHK_WAIT.
REQ-016 IDLE: if a shuffle is pending, SHALL go to SHK_TRG; else if req is nonzero, SHALL latch the round-robin winner and go to STEP; else SHALL stay.
REQ-017 A pending shuffle SHALL take priority over draws.
REQ-018 STEP: gen_en SHALL be 1 for exactly one cycle; next state DELIVER.
REQ-019 DELIVER: rnd_vld=1, gnt=onehot(winner), rnd_data=lfsr for one cycle; next state IDLE.
REQ-020 Latency from req sampled in IDLE to gnt SHALL be 2 cycles; sustained throughput 1 draw per 3 cycles.
REQ-021 Round-robin: search SHALL start at ptr; after each grant, ptr <= (winner+1) mod GP_NUM_REQ.
REQ-022 A requester dropping req after being latched SHALL still receive its grant.
REQ-023 SHK_TRG: rgen_trg SHALL be 1 for one cycle; next state SHK_WAIT; gen_en SHALL be 0.
REQ-024 SHK_WAIT: SHALL count GP_SHK_WAIT cycles, then return to IDLE; no grants during this state.
REQ-025 shk_req SHALL set a sticky pending flag, cleared on entry to SHK_TRG.
REQ-026 shk_req arriving in any state, including SHK_TRG or SHK_WAIT, SHALL set the pending flag; multiple pulses before service SHALL collapse to one shuffle.
REQ-027 gen_en and rgen_trg SHALL never be high in the same cycle.
REQ-028 gnt, rnd_vld, gen_en and rgen_trg SHALL be registered outputs.
REQ-029 When rnd_vld=0, rnd_data SHALL hold its last delivered value.

Reset
REQ-030 rst_n low SHALL asynchronously force: state IDLE, ptr 0, pending 0, wait counter 0, draw counter 0, and gnt, rnd_vld, rnd_data, busy, gen_en, rgen_trg all 0.
REQ-031 Reset asserted mid-operation SHALL abort the operation; no grant SHALL be issued for the aborted draw.

Configuration
REQ-032 SHALL provide macro LFSR_ARB_AUTO_SHK_EN.
REQ-033 With LFSR_ARB_AUTO_SHK_EN defined: a 16-bit draw counter SHALL increment on each DELIVER; on reaching GP_RESHUFFLE_PERIOD it SHALL set the pending flag and clear to 0.
REQ-034 Without LFSR_ARB_AUTO_SHK_EN: no draw counter SHALL exist, and reshuffles SHALL occur only via shk_req.

Structure
REQ-035 Package lfsr_pkg SHALL hold the FSM state enum and the LFSR width constant (16).
REQ-036 Round-robin winner selection SHALL be a sub-module named rr_pick, combinational, taking req and ptr and returning winner index and a found flag.

Verification
REQ-037 Single draw: req=0001 with lfsr at seed 1 -> gen_en at cycle+1, gnt=0001, rnd_vld=1 at cycle+2, rnd_data=the stepped lfsr value.
REQ-038 Fairness: req=1111 held for 12 draws -> grants in order 0,1,2,3 repeating, each exactly 3 times.
REQ-039 Shuffle priority: shk_req and req=0010 in the same IDLE cycle -> rgen_trg pulse, busy for 1+GP_SHK_WAIT cycles, then grant to requester 1.
REQ-040 Collapse: 3 shk_req pulses during SHK_WAIT -> exactly one further rgen_trg pulse.
REQ-041 Reset mid-draw: rst_n low during STEP -> all outputs 0 immediately; no gnt after release until a new req.
REQ-042 Auto reshuffle, macro defined, GP_RESHUFFLE_PERIOD=4: 8 draws -> exactly 2 rgen_trg pulses, one after draw 4 and one after draw 8.

Source files
------------

// File: rtl/lfsr_pkg.sv
// lfsr_pkg: FSM state encoding and LFSR width shared by lfsr_arb and rr_pick.
package lfsr_pkg;
  localparam int LFSR_W = 16;
  typedef enum logic [2:0] {IDLE, STEP, DELIVER, SHK_TRG, SHK_WAIT} state_t;
endpackage

// File: rtl/lfsr_arb_rr_pick.sv
// rr_pick: combinational round-robin search over req, starting at ptr.
module rr_pick
  import lfsr_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          found
);
  logic [IW-1:0] k;
  always_comb begin
    winner = '0;
    found  = 1'b0;
    k      = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = IW'((int'(ptr) + i) % N);
      if (req[k]) begin
        winner = k;
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/lfsr_arb.sv
// lfsr_arb: round-robin arbiter handing out external LFSR values, with reshuffle control.
// Optional LFSR_ARB_AUTO_SHK_EN adds an automatic reshuffle every GP_RESHUFFLE_PERIOD draws.
module lfsr_arb
  import lfsr_pkg::*;
#(
  parameter int GP_NUM_REQ          = 4,
  parameter int GP_SHK_WAIT         = 8,
  parameter int GP_RESHUFFLE_PERIOD = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [GP_NUM_REQ-1:0] req,
  input  logic                  shk_req,
  output logic [GP_NUM_REQ-1:0] gnt,
  output logic                  rnd_vld,
  output logic [LFSR_W-1:0]     rnd_data,
  output logic                  busy,
  output logic                  gen_en,
  output logic                  rgen_trg,
  input  logic [LFSR_W-1:0]     lfsr
);
  localparam int IW = $clog2(GP_NUM_REQ);

  if (GP_NUM_REQ < 2 || GP_NUM_REQ > 8 || GP_SHK_WAIT < 1 || GP_SHK_WAIT > 255 ||
      GP_RESHUFFLE_PERIOD < 1 || GP_RESHUFFLE_PERIOD > 65535) begin : g_bad_param
    $error("lfsr_arb: parameter out of range");
  end

  state_t            state, nxt;
  logic [IW-1:0]     ptr, win, pick;
  logic              found, pend, auto_shk;
  logic [7:0]        wait_cnt;
  logic [LFSR_W-1:0] data_q;

  rr_pick #(.N(GP_NUM_REQ), .IW(IW)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (pick),
    .found  (found)
  );

  // shk_req is honoured in the same IDLE cycle it arrives, ahead of any draw
  always_comb
    nxt = state == IDLE     ? ((pend || shk_req) ? SHK_TRG : found ? STEP : IDLE) :
          state == STEP     ? DELIVER :
          state == SHK_TRG  ? SHK_WAIT :
          (state == SHK_WAIT && wait_cnt != 8'(GP_SHK_WAIT - 1)) ? SHK_WAIT : IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      win      <= '0;
      pend     <= 1'b0;
      wait_cnt <= '0;
      data_q   <= '0;
      gnt      <= '0;
      rnd_vld  <= 1'b0;
      gen_en   <= 1'b0;
      rgen_trg <= 1'b0;
    end else begin
      state    <= nxt;
      pend     <= (pend | shk_req | auto_shk) & (nxt != SHK_TRG);
      wait_cnt <= state == SHK_WAIT ? wait_cnt + 8'd1 : 8'd0;
      if (state == IDLE && nxt == STEP) win <= pick;
      if (state == DELIVER) ptr <= win == IW'(GP_NUM_REQ - 1) ? '0 : win + 1'b1;
      if (state == DELIVER) data_q <= lfsr;
      gen_en   <= nxt == STEP;
      rgen_trg <= nxt == SHK_TRG;
      rnd_vld  <= nxt == DELIVER;
      gnt      <= nxt == DELIVER ? {{(GP_NUM_REQ-1){1'b0}}, 1'b1} << win : '0;
    end
  end

  // lfsr has already stepped by DELIVER, so it is passed straight through while valid
  assign rnd_data = rnd_vld ? lfsr : data_q;
  assign busy     = state != IDLE;

`ifdef LFSR_ARB_AUTO_SHK_EN
  logic [15:0] draw_cnt;
  assign auto_shk = state == DELIVER && draw_cnt == 16'(GP_RESHUFFLE_PERIOD - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) draw_cnt <= '0;
    else if (state == DELIVER) draw_cnt <= auto_shk ? '0 : draw_cnt + 16'd1;
  end
`else
  assign auto_shk = 1'b0;
`endif
endmodule
